alu_cmd_writer: RTL and testbench
=================================

ALU_CMD_WRITER -- requirements
Module: alu_cmd_writer

Interface
REQ-001 Parameter DATA_W, default 8: width of opcode and operand bytes.
REQ-002 Parameter FIFO_DEPTH, default 2: command buffer entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command buffer can accept.
REQ-007 cmd_op  input  1  0 = add, 1 = sub.
REQ-008 cmd_a  input  DATA_W  first operand.
REQ-009 cmd_b  input  DATA_W  second operand.
REQ-010 byte_valid  output  1  stream byte present.
REQ-011 byte_ready  input  1  sink accepts byte.
REQ-012 byte_data  output  DATA_W  stream byte.
REQ-013 byte_last  output  1  high on the final byte (operand B) of a frame.
REQ-014 busy  output  1  FSM not IDLE or buffer non-empty.
REQ-015 exp_valid  output  1  one-cycle pulse when a frame completes.
REQ-016 exp_result  output  DATA_W  expected ALU result of the last completed frame.
REQ-017 cmd_count  output  16  count of completed frames.

Function
REQ-018 Frame format SHALL be three bytes in order: opcode (8'h00 add, 8'h01 sub, zero-extended to DATA_W), cmd_a, cmd_b.
REQ-019 Command accept SHALL occur on an edge with cmd_valid && cmd_ready; cmd_ready SHALL be !fifo_full, registered, with no pass-through when full.
REQ-020 Simultaneous push and pop SHALL be allowed when the buffer is not full; occupancy then stays unchanged.
REQ-021 FSM states SHALL be IDLE, OPC, OPA, OPB.
REQ-022 IDLE with non-empty buffer: pop head into a frame register, go to OPC on the same edge.
REQ-023 OPC→OPA→OPB SHALL advance only on byte_valid && byte_ready.
REQ-024 byte_valid SHALL be high exactly in OPC/OPA/OPB; byte_data and byte_last SHALL hold stable while byte_valid && !byte_ready.
REQ-025 OPB handshake: if the buffer is non-empty, pop and go to OPC directly (no bubble), else go to IDLE.
REQ-026 Latency: command accepted at edge N into an idle, empty block gives byte_valid high after edge N+1.
REQ-027 On OPB handshake: exp_result = a+b or a−b modulo 2^DATA_W; exp_valid pulses for one cycle; cmd_count increments, wrapping 16'hFFFF→0.
REQ-028 exp_result SHALL hold its value between pulses.
REQ-029 byte_ready held low SHALL stall indefinitely without loss; new commands SHALL buffer until full.

Reset
REQ-030 rst_n low SHALL immediately force: FSM IDLE, buffer empty, byte_valid 0, byte_data 0, byte_last 0, exp_valid 0, exp_result 0, cmd_count 0, busy 0, cmd_ready 0.
REQ-031 cmd_ready SHALL rise on the first edge after rst_n deasserts.
REQ-032 Reset mid-frame SHALL discard the partial frame and all buffered commands; no byte_valid SHALL appear after release until a new command is accepted.

Structure
REQ-033 Package alu_cmd_pkg SHALL hold OP_ADD/OP_SUB constants, the FSM state enum, and the DATA_W default.
REQ-034 Sub-module cmd_fifo (synchronous FIFO, push/pop/full/empty, width 1+2*DATA_W) SHALL implement the buffer.

Verification
REQ-035 Single add: op=0, a=8'h05, b=8'h03, byte_ready=1 → bytes 00,05,03; byte_last on 03; exp_result 8'h08; cmd_count 1.
REQ-036 Sub wrap: op=1, a=8'h02, b=8'h05 → bytes 01,02,05; exp_result 8'hFD.
REQ-037 Back-to-back: three commands pushed while byte_ready=1 → nine consecutive byte_valid cycles with no bubble; cmd_ready low when 2 are buffered.
REQ-038 Backpressure: byte_ready low for 5 cycles during OPA → byte_data stays cmd_a; frame then completes intact.
REQ-039 Reset mid-frame: rst_n low during OPA → outputs zero immediately; after release byte_valid stays 0 until a new command is accepted.
REQ-040 Counter wrap: preload 65535 completed frames (or force) → next completion gives cmd_count 0.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared constants and state encoding for the ALU command frame writer.
package alu_cmd_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPC  = 2'd1,
    ST_OPA  = 2'd2,
    ST_OPB  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/alu_cmd_writer_if.sv
// Command input handshake plus byte-stream output handshake of the frame writer.
interface alu_cmd_writer_if import alu_cmd_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic              byte_valid;
  logic              byte_ready;
  logic [DATA_W-1:0] byte_data;
  logic              byte_last;

  // Environment side: offers commands, sinks bytes.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, byte_ready,
    input  cmd_ready, byte_valid, byte_data, byte_last
  );

  // Writer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, byte_ready,
    output cmd_ready, byte_valid, byte_data, byte_last
  );

endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding pending commands; head is visible on rd_data.
module cmd_fifo import alu_cmd_pkg::*; #(
  parameter int WIDTH = 1 + 2 * DATA_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; requests against full/empty are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_writer.sv
// Turns buffered add/sub commands into 3-byte frames (opcode, a, b) and
// reports the expected ALU result and a frame count as each frame completes.
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_IDLE | no frame in flight, waiting for a buffered command
//   ST_OPC  | presenting opcode byte
//   ST_OPA  | presenting operand A
//   ST_OPB  | presenting operand B (last byte of frame)
module alu_cmd_writer import alu_cmd_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_writer_if.slave   bus,
  output logic              busy,
  output logic              exp_valid,
  output logic [DATA_W-1:0] exp_result,
  output logic [15:0]       cmd_count
);

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  wr_state_e         state_q;
  cmd_t              frame_q;
  cmd_t              fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rdy_q;
  logic              push;
  logic              pop;
  logic              byte_hs;
  logic              byte_valid_q;
  logic [DATA_W-1:0] byte_data_q;
  logic              byte_last_q;
  logic              exp_valid_q;
  logic [DATA_W-1:0] exp_result_q;
  logic [15:0]       cmd_count_q;

  function automatic logic [DATA_W-1:0] opc_byte(input logic op);
    return {{(DATA_W-1){1'b0}}, op};
  endfunction

  function automatic logic [DATA_W-1:0] alu_result(input cmd_t c);
    return (c.op == OP_SUB) ? (c.a - c.b) : (c.a + c.b);
  endfunction

  // rdy_q holds cmd_ready low through reset and the first edge after it;
  // fifo_full is a flop-derived flag, so there is no combinational path from cmd_valid.
  assign bus.cmd_ready  = rdy_q & ~fifo_full;
  assign push           = bus.cmd_valid & bus.cmd_ready;
  assign byte_hs        = byte_valid_q & bus.byte_ready;
  assign pop            = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_OPB) && byte_hs));

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_last  = byte_last_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;
  assign exp_valid      = exp_valid_q;
  assign exp_result     = exp_result_q;
  assign cmd_count      = cmd_count_q;

  cmd_fifo #(
    .WIDTH (1 + 2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencer with registered stream and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      rdy_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_last_q  <= 1'b0;
      exp_valid_q  <= 1'b0;
      exp_result_q <= '0;
      cmd_count_q  <= '0;
    end else begin
      rdy_q       <= 1'b1;
      exp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            frame_q      <= fifo_head;
            state_q      <= ST_OPC;
            byte_valid_q <= 1'b1;
            byte_data_q  <= opc_byte(fifo_head.op);
            byte_last_q  <= 1'b0;
          end
        end
        ST_OPC: begin
          if (byte_hs) begin
            state_q     <= ST_OPA;
            byte_data_q <= frame_q.a;
          end
        end
        ST_OPA: begin
          if (byte_hs) begin
            state_q     <= ST_OPB;
            byte_data_q <= frame_q.b;
            byte_last_q <= 1'b1;
          end
        end
        ST_OPB: begin
          if (byte_hs) begin
            exp_result_q <= alu_result(frame_q);
            exp_valid_q  <= 1'b1;
            cmd_count_q  <= cmd_count_q + 16'd1;
            // Chain straight into the next frame when one is waiting.
            if (!fifo_empty) begin
              frame_q      <= fifo_head;
              state_q      <= ST_OPC;
              byte_data_q  <= opc_byte(fifo_head.op);
              byte_last_q  <= 1'b0;
            end else begin
              state_q      <= ST_IDLE;
              byte_valid_q <= 1'b0;
              byte_data_q  <= '0;
              byte_last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_writer.sv
// Directed bench for alu_cmd_writer: reset, add/sub frames, back-to-back,
// backpressure, mid-frame reset and frame counter wrap.
module tb_alu_cmd_writer;
  import alu_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic        exp_valid;
  logic [7:0]  exp_result;
  logic [15:0] cmd_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q_byte[$];
  logic       q_last[$];
  logic [7:0] q_exp[$];
  int         n_valid = 0;
  int         n_exp = 0;
  int         run_len = 0;
  int         last_run = 0;

  alu_cmd_writer_if #(.DATA_W(8)) bus ();

  alu_cmd_writer #(.DATA_W(8), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .exp_valid  (exp_valid),
    .exp_result (exp_result),
    .cmd_count  (cmd_count)
  );

  always #5 clk = ~clk;

  // Stream/result monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.byte_valid && bus.byte_ready) begin
        q_byte.push_back(bus.byte_data);
        q_last.push_back(bus.byte_last);
      end
      if (bus.byte_valid) begin
        n_valid++;
        run_len++;
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (exp_valid) begin
        q_exp.push_back(exp_result);
        n_exp++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic op, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!bus.cmd_ready) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (n_exp < target && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (n_exp < target) chk("frame_timeout", n_exp, target);
  endtask

  task automatic chk_stream(input string tag, input int base, input logic [7:0] e[$]);
    chk({tag, "_nbytes"}, q_byte.size() - base, e.size());
    for (int i = 0; i < e.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, q_byte[base + i]}, {24'd0, e[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, q_last[base + i]}, {31'd0, (i % 3 == 2)});
    end
  endtask

  task automatic chk_results(input string tag, input int base, input logic [7:0] e[$]);
    chk({tag, "_nres"}, q_exp.size() - base, e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_res%0d", tag, i), {24'd0, q_exp[base + i]}, {24'd0, e[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] eb[$];
    logic [7:0] er[$];
    int         bb, be, ne;

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'b0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.byte_ready = 1'b1;

    // Reset values.
    #12;
    chk("rst_byte_valid", bus.byte_valid, 1'b0);
    chk("rst_byte_data",  bus.byte_data, 8'h00);
    chk("rst_byte_last",  bus.byte_last, 1'b0);
    chk("rst_exp_valid",  exp_valid, 1'b0);
    chk("rst_exp_result", exp_result, 8'h00);
    chk("rst_cmd_count",  cmd_count, 16'h0000);
    chk("rst_busy",       busy, 1'b0);
    chk("rst_cmd_ready",  bus.cmd_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready_pre", bus.cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rel_cmd_ready_post", bus.cmd_ready, 1'b1);

    // Single add with one-cycle latency into the stream.
    bb = q_byte.size(); be = q_exp.size();
    push(OP_ADD, 8'h05, 8'h03);
    chk("add_lat_pre", bus.byte_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("add_lat_post", bus.byte_valid, 1'b1);
    wait_frames(1);
    chk("add_pulse_width", exp_valid, 1'b0);
    eb = '{8'h00, 8'h05, 8'h03};
    chk_stream("add", bb, eb);
    er = '{8'h08};
    chk_results("add", be, er);
    chk("add_count", cmd_count, 16'd1);
    chk("add_busy", busy, 1'b0);

    // Subtract with wrap; result must persist between pulses.
    bb = q_byte.size(); be = q_exp.size();
    push(OP_SUB, 8'h02, 8'h05);
    wait_frames(2);
    repeat (4) @(posedge clk);
    #1;
    eb = '{8'h01, 8'h02, 8'h05};
    chk_stream("sub", bb, eb);
    er = '{8'hFD};
    chk_results("sub", be, er);
    chk("sub_hold", exp_result, 8'hFD);
    chk("sub_count", cmd_count, 16'd2);

    // Back-to-back commands: continuous cmd_valid, nine bubble-free bytes.
    bb = q_byte.size(); be = q_exp.size();
    bus.cmd_op = OP_ADD; bus.cmd_a = 8'h10; bus.cmd_b = 8'h20;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.cmd_ready && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (!bus.cmd_ready) chk("burst_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (i == 0) begin bus.cmd_op = OP_SUB; bus.cmd_a = 8'h10; bus.cmd_b = 8'h20; end
      if (i == 1) begin bus.cmd_op = OP_ADD; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h01; end
    end
    bus.cmd_valid = 1'b0;
    chk("burst_full_ready", bus.cmd_ready, 1'b0);
    wait_frames(5);
    @(posedge clk);
    #2;
    chk("burst_run", last_run, 9);
    eb = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h10, 8'h20, 8'h00, 8'hFF, 8'h01};
    chk_stream("burst", bb, eb);
    er = '{8'h30, 8'hF0, 8'h00};
    chk_results("burst", be, er);
    chk("burst_count", cmd_count, 16'd5);

    // Backpressure in OPA while two more commands fill the buffer.
    bb = q_byte.size(); be = q_exp.size();
    bus.byte_ready = 1'b0;
    push(OP_ADD, 8'hA5, 8'h5A);
    @(posedge clk);
    #1;
    chk("bp_opc_data", bus.byte_data, 8'h00);
    bus.byte_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_ready = 1'b0;
    push(OP_SUB, 8'h30, 8'h10);
    push(OP_ADD, 8'h80, 8'h80);
    chk("bp_full_ready", bus.cmd_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_stall_data%0d", i), bus.byte_data, 8'hA5);
      chk($sformatf("bp_stall_valid%0d", i), bus.byte_valid, 1'b1);
      chk($sformatf("bp_stall_last%0d", i), bus.byte_last, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.byte_ready = 1'b1;
    wait_frames(8);
    eb = '{8'h00, 8'hA5, 8'h5A, 8'h01, 8'h30, 8'h10, 8'h00, 8'h80, 8'h80};
    chk_stream("bp", bb, eb);
    er = '{8'hFF, 8'h20, 8'h00};
    chk_results("bp", be, er);
    chk("bp_count", cmd_count, 16'd8);

    // Reset in the middle of a frame with a command buffered behind it.
    bus.byte_ready = 1'b0;
    push(OP_ADD, 8'h11, 8'h22);
    @(posedge clk);
    #1;
    bus.byte_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_ready = 1'b0;
    push(OP_ADD, 8'h33, 8'h44);
    chk("mr_opa_data", bus.byte_data, 8'h11);
    rst_n = 1'b0;
    #1;
    chk("mr_byte_valid", bus.byte_valid, 1'b0);
    chk("mr_byte_data",  bus.byte_data, 8'h00);
    chk("mr_exp_result", exp_result, 8'h00);
    chk("mr_cmd_count",  cmd_count, 16'd0);
    chk("mr_busy",       busy, 1'b0);
    chk("mr_cmd_ready",  bus.cmd_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.byte_ready = 1'b1;
    ne = n_exp;
    bb = n_valid;
    repeat (10) @(negedge clk);
    chk("mr_no_valid", n_valid - bb, 0);
    chk("mr_no_exp", n_exp - ne, 0);
    bb = q_byte.size(); be = q_exp.size();
    @(posedge clk);
    #1;
    push(OP_ADD, 8'h01, 8'h01);
    wait_frames(ne + 1);
    eb = '{8'h00, 8'h01, 8'h01};
    chk_stream("mr", bb, eb);
    er = '{8'h02};
    chk_results("mr", be, er);
    chk("mr_count", cmd_count, 16'd1);

    // Frame counter wrap from 16'hFFFF.
    @(posedge clk);
    #1;
    force dut.cmd_count_q = 16'hFFFF;
    #1;
    release dut.cmd_count_q;
    #1;
    chk("wrap_preload", cmd_count, 16'hFFFF);
    be = q_exp.size();
    push(OP_SUB, 8'h00, 8'h01);
    wait_frames(ne + 2);
    er = '{8'hFF};
    chk_results("wrap", be, er);
    chk("wrap_count", cmd_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
